// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and types for the instruction fetch stage.
//   NOP_INSTR_C  - bubble instruction (addi x0,x0,0)
//   RESET_PC_C   - default first fetch address
//   FETCH_DEPTH  - depth of the pending-PC queue and of the response buffer;
//                  also the credit limit on outstanding + buffered fetches
//   fetch_entry_t - {pc, instr} pair carried through the fetch buffers
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR_C = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_C  = 32'h0000_0000;
  localparam int          FETCH_DEPTH = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Clears the byte-offset bits so every fetch address is word aligned.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: 2-entry FIFO of fetch_entry_t.
// Used twice by fetch_stage: as the pending-PC queue of issued fetches and
// as the response buffer that absorbs returned words while ID is stalled.
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   push_i         write push_data_i at the tail
//   push_data_i    entry to write
//   pop_i          drop the head entry
//   flush_i        empty the FIFO (wins over push/pop)
//   head_o         oldest entry (valid when count_o != 0)
//   count_o        number of stored entries, 0..2
// Push and pop in the same cycle are allowed, including when full.
module fetch_buffer
  import fetch_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  fetch_entry_t push_data_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output fetch_entry_t head_o,
  output logic [1:0]   count_o
);

  fetch_entry_t r_mem [FETCH_DEPTH];
  logic         r_rd_ptr;
  logic         r_wr_ptr;
  logic [1:0]   r_count;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
      for (int i = 0; i < FETCH_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (flush_i) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (push_i) begin
        r_mem[r_wr_ptr] <= push_data_i;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (pop_i) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({push_i, pop_i})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign head_o  = r_mem[r_rd_ptr];
  assign count_o = r_count;

  // The credit rule upstream must keep these from ever happening.
  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(push_i && !pop_i && !flush_i && (r_count == 2'd2)));
  a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(pop_i && !flush_i && (r_count == 2'd0)));

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: RV32I instruction fetch stage feeding ID.
// Owns the PC, issues word fetches on a req/gnt/rvalid memory port, buffers
// up to two returned words across ID stalls and squashes wrong-path fetches
// on a redirect from ID.
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   ID_stall_i          hold the IF/ID register
//   PCSrc_i             redirect to Branch_target_i (wins over ID_stall_i)
//   Branch_target_i     redirect address, low two bits ignored
//   Imem_req_o/addr_o   fetch request and word address
//   Imem_gnt_i          request accepted this cycle
//   Imem_rvalid_i/rdata_i  in-order response
//   IF_Instruction_o/IF_PC_o/IF_valid_o  IF/ID register contents
// Note: PCSrc_i reaches Imem_req_o combinationally.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_C,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_C
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ID_stall_i,
  input  logic        PCSrc_i,
  input  logic [31:0] Branch_target_i,
  output logic        Imem_req_o,
  output logic [31:0] Imem_addr_o,
  input  logic        Imem_gnt_i,
  input  logic        Imem_rvalid_i,
  input  logic [31:0] Imem_rdata_i,
  output logic [31:0] IF_Instruction_o,
  output logic [31:0] IF_PC_o,
  output logic        IF_valid_o
);

  logic [31:0]  r_pc;
  logic [1:0]   r_drop;
  logic [31:0]  r_if_instr;
  logic [31:0]  r_if_pc;
  logic         r_if_valid;

  fetch_entry_t w_pend_push;
  fetch_entry_t w_pend_head;
  fetch_entry_t w_buf_head;
  fetch_entry_t w_resp;
  logic [1:0]   w_outstanding;
  logic [1:0]   w_buffered;
  logic [2:0]   w_credit_used;
  logic [1:0]   w_out_after;
  logic         w_issue;
  logic         w_dropping;
  logic         w_resp_keep;
  logic         w_advance;
  logic         w_buf_pop;
  logic         w_buf_push;
  logic         w_bypass;
  logic         w_unused_instr;

  // Every fetch that is in flight or sitting in the buffer holds a slot,
  // so the response buffer can never overflow.
  assign w_credit_used = {1'b0, w_outstanding} + {1'b0, w_buffered};
  assign Imem_req_o    = !rst_i && !PCSrc_i && (w_credit_used < 3'(FETCH_DEPTH));
  assign Imem_addr_o   = r_pc;
  assign w_issue       = Imem_req_o && Imem_gnt_i;

  // A response is kept only when no wrong-path words are still owed and no
  // redirect is squashing the current one.
  assign w_dropping  = (r_drop != 2'd0);
  assign w_resp_keep = Imem_rvalid_i && !w_dropping && !PCSrc_i;
  assign w_resp      = '{pc: w_pend_head.pc, instr: Imem_rdata_i};

  assign w_advance  = !PCSrc_i && !ID_stall_i;
  assign w_buf_pop  = w_advance && (w_buffered != 2'd0);
  assign w_bypass   = w_advance && (w_buffered == 2'd0) && w_resp_keep;
  assign w_buf_push = w_resp_keep && !w_bypass;

  // No request is issued during a redirect, so only the response can
  // change the outstanding count in that cycle.
  assign w_out_after = w_outstanding - {1'b0, Imem_rvalid_i};

  assign w_pend_push    = '{pc: r_pc, instr: 32'h0};
  assign w_unused_instr = ^w_pend_head.instr;

  // Pending-PC queue: one entry per issued, unreturned fetch. Every
  // response pops it, whether kept or dropped.
  fetch_buffer u_pending (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (w_issue),
    .push_data_i (w_pend_push),
    .pop_i       (Imem_rvalid_i),
    .flush_i     (1'b0),
    .head_o      (w_pend_head),
    .count_o     (w_outstanding)
  );

  // Response buffer: kept {pc, instr} pairs waiting for ID.
  fetch_buffer u_resp_buf (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (w_buf_push),
    .push_data_i (w_resp),
    .pop_i       (w_buf_pop),
    .flush_i     (PCSrc_i),
    .head_o      (w_buf_head),
    .count_o     (w_buffered)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pc <= RESET_PC;
    end else if (PCSrc_i) begin
      r_pc <= word_align(Branch_target_i);
    end else if (w_issue) begin
      r_pc <= r_pc + 32'd4;
    end
  end

  // Drop count: words still in flight at a redirect are wrong-path.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_drop <= 2'd0;
    end else if (PCSrc_i) begin
      r_drop <= w_out_after;
    end else if (Imem_rvalid_i && w_dropping) begin
      r_drop <= r_drop - 2'd1;
    end
  end

  // IF/ID register. On a bubble the PC is left alone; only valid and the
  // instruction word change.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_if_instr <= NOP_INSTR;
      r_if_pc    <= 32'h0;
      r_if_valid <= 1'b0;
    end else if (PCSrc_i) begin
      r_if_instr <= NOP_INSTR;
      r_if_valid <= 1'b0;
    end else if (!ID_stall_i) begin
      if (w_buf_pop) begin
        r_if_instr <= w_buf_head.instr;
        r_if_pc    <= w_buf_head.pc;
        r_if_valid <= 1'b1;
      end else if (w_bypass) begin
        r_if_instr <= w_resp.instr;
        r_if_pc    <= w_resp.pc;
        r_if_valid <= 1'b1;
      end else begin
        r_if_instr <= NOP_INSTR;
        r_if_valid <= 1'b0;
      end
    end
  end

  assign IF_Instruction_o = r_if_instr;
  assign IF_PC_o          = r_if_pc;
  assign IF_valid_o       = r_if_valid;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed self-checking bench for fetch_stage.
// A memory model answers granted fetches after a programmable latency.
// Granted fetches push their expected {pc, instr} into a scoreboard queue;
// each instruction that reaches IF/ID pops and compares. A redirect clears
// the queue because everything fetched before it is wrong-path.
module tb_fetch_stage;
  import fetch_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        ID_stall_i = 1'b0;
  logic        PCSrc_i = 1'b0;
  logic [31:0] Branch_target_i = 32'h0;
  logic        Imem_req_o;
  logic [31:0] Imem_addr_o;
  logic        Imem_gnt_i = 1'b1;
  logic        Imem_rvalid_i = 1'b0;
  logic [31:0] Imem_rdata_i = 32'h0;
  logic [31:0] IF_Instruction_o;
  logic [31:0] IF_PC_o;
  logic        IF_valid_o;

  always #5 clk_i = ~clk_i;

  fetch_stage #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (32'h0000_0013)
  ) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .ID_stall_i       (ID_stall_i),
    .PCSrc_i          (PCSrc_i),
    .Branch_target_i  (Branch_target_i),
    .Imem_req_o       (Imem_req_o),
    .Imem_addr_o      (Imem_addr_o),
    .Imem_gnt_i       (Imem_gnt_i),
    .Imem_rvalid_i    (Imem_rvalid_i),
    .Imem_rdata_i     (Imem_rdata_i),
    .IF_Instruction_o (IF_Instruction_o),
    .IF_PC_o          (IF_PC_o),
    .IF_valid_o       (IF_valid_o)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mem_req_t;

  typedef enum int {K_LOAD, K_HOLD, K_BUBBLE} kind_e;

  localparam logic [31:0] NOP = 32'h0000_0013;

  mem_req_t     mem_q[$];
  fetch_entry_t exp_q[$];

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          lat = 1;
  int          issue_cnt = 0;
  logic [31:0] exp_addr = 32'h0;
  logic [31:0] last_issue = 32'h0;
  kind_e       prev_kind = K_BUBBLE;
  logic [31:0] m_pc = 32'h0;
  logic [31:0] m_instr = NOP;
  logic        m_valid = 1'b0;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[29:0], 2'b11} ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, expv);
    end
  endtask

  // Called at the falling edge: outputs reflect the last rising edge and
  // all combinational paths have settled.
  task automatic monitor();
    fetch_entry_t e;
    if (rst_i) begin
      chk("rst_instr", IF_Instruction_o, NOP);
      chk("rst_pc", IF_PC_o, 32'h0);
      chk("rst_valid", {31'h0, IF_valid_o}, 32'h0);
      chk("rst_req", {31'h0, Imem_req_o}, 32'h0);
      mem_q.delete();
      exp_q.delete();
      exp_addr  = RESET_PC_C;
      m_pc      = 32'h0;
      m_instr   = NOP;
      m_valid   = 1'b0;
      prev_kind = K_BUBBLE;
      $display("cyc=%0d reset", cyc);
      return;
    end
    case (prev_kind)
      K_LOAD: begin
        if (IF_valid_o) begin
          chk("spurious_valid", {31'h0, exp_q.size() != 0}, 32'h1);
          if (exp_q.size() != 0) begin
            e       = exp_q.pop_front();
            m_pc    = e.pc;
            m_instr = e.instr;
            m_valid = 1'b1;
          end
        end else begin
          m_instr = NOP;
          m_valid = 1'b0;
        end
      end
      K_BUBBLE: begin
        m_instr = NOP;
        m_valid = 1'b0;
      end
      default: ;
    endcase
    chk("if_pc", IF_PC_o, m_pc);
    chk("if_instr", IF_Instruction_o, m_instr);
    chk("if_valid", {31'h0, IF_valid_o}, {31'h0, m_valid});
    if (Imem_req_o) chk("req_addr", Imem_addr_o, exp_addr);
    if (Imem_rvalid_i && mem_q.size() != 0) void'(mem_q.pop_front());
    if (PCSrc_i) begin
      chk("redir_req", {31'h0, Imem_req_o}, 32'h0);
      exp_q.delete();
      exp_addr  = Branch_target_i & ~32'h3;
      prev_kind = K_BUBBLE;
    end else begin
      if (Imem_req_o && Imem_gnt_i) begin
        mem_q.push_back('{addr: Imem_addr_o, due: cyc + lat});
        exp_q.push_back('{pc: exp_addr, instr: instr_of(exp_addr)});
        last_issue = exp_addr;
        exp_addr   = exp_addr + 32'd4;
        issue_cnt++;
      end
      prev_kind = ID_stall_i ? K_HOLD : K_LOAD;
    end
    $display("cyc=%0d req=%0b addr=%08h gnt=%0b rvalid=%0b stall=%0b pcsrc=%0b if_valid=%0b if_pc=%08h if_instr=%08h",
             cyc, Imem_req_o, Imem_addr_o, Imem_gnt_i, Imem_rvalid_i, ID_stall_i, PCSrc_i,
             IF_valid_o, IF_PC_o, IF_Instruction_o);
  endtask

  task automatic tick();
    @(negedge clk_i);
    monitor();
    @(posedge clk_i);
    #1;
    cyc++;
    if (!rst_i && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      Imem_rvalid_i = 1'b1;
      Imem_rdata_i  = instr_of(mem_q[0].addr);
    end else begin
      Imem_rvalid_i = 1'b0;
      Imem_rdata_i  = 32'hDEAD_BEEF;
    end
  endtask

  task automatic wait_valid_pc(input string tag, input logic [31:0] pc, input int budget);
    int n;
    n = 0;
    while (!IF_valid_o && n < budget) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, {31'h0, IF_valid_o}, 32'h1);
    chk({tag, "_pc"}, IF_PC_o, pc);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    int base;
    int n;
    logic [31:0] held;

    // Reset state
    tick();
    tick();
    chk("reset_instr", IF_Instruction_o, NOP);
    chk("reset_pc", IF_PC_o, 32'h0);
    chk("reset_valid", {31'h0, IF_valid_o}, 32'h0);
    chk("reset_req", {31'h0, Imem_req_o}, 32'h0);
    chk("reset_addr", Imem_addr_o, 32'h0);

    // Release: first request immediately, first valid two cycles later
    rst_i = 1'b0;
    #1;
    chk("first_req", {31'h0, Imem_req_o}, 32'h1);
    chk("first_addr", Imem_addr_o, 32'h0);
    tick();
    chk("lat_not_yet", {31'h0, IF_valid_o}, 32'h0);
    tick();
    chk("first_valid", {31'h0, IF_valid_o}, 32'h1);
    chk("first_pc", IF_PC_o, 32'h0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("stream_valid", {31'h0, IF_valid_o}, 32'h1);
      chk("stream_pc", IF_PC_o, 32'(4 * i));
    end

    // ID stall for three cycles while 0x10 sits in IF/ID
    ID_stall_i = 1'b1;
    base = issue_cnt;
    #1;
    chk("stall_req0", {31'h0, Imem_req_o}, 32'h1);
    tick();
    chk("stall_req1", {31'h0, Imem_req_o}, 32'h0);
    chk("stall_hold1", IF_PC_o, 32'h10);
    tick();
    chk("stall_req2", {31'h0, Imem_req_o}, 32'h0);
    chk("stall_hold2", IF_PC_o, 32'h10);
    tick();
    ID_stall_i = 1'b0;
    chk("stall_last_issue", last_issue, 32'h18);
    chk("stall_issue_cnt", 32'(issue_cnt - base), 32'd1);
    chk("stall_hold3", IF_PC_o, 32'h10);
    tick();
    chk("unstall_pc14", IF_PC_o, 32'h14);
    tick();
    chk("unstall_pc18", IF_PC_o, 32'h18);
    tick();
    chk("unstall_pc1c", IF_PC_o, 32'h1C);
    chk("unstall_valid", {31'h0, IF_valid_o}, 32'h1);

    // Redirect with two fetches outstanding (2-cycle memory)
    lat = 2;
    n = 0;
    while (mem_q.size() != 2 && n < 12) begin
      tick();
      n++;
    end
    chk("two_outstanding", 32'(mem_q.size()), 32'd2);
    PCSrc_i = 1'b1;
    Branch_target_i = 32'h0000_0103;
    #1;
    chk("redir_no_req", {31'h0, Imem_req_o}, 32'h0);
    tick();
    PCSrc_i = 1'b0;
    Branch_target_i = 32'h0;
    #1;
    chk("redir_bubble_valid", {31'h0, IF_valid_o}, 32'h0);
    chk("redir_bubble_instr", IF_Instruction_o, NOP);
    chk("redir_req", {31'h0, Imem_req_o}, 32'h1);
    chk("redir_addr", Imem_addr_o, 32'h100);
    wait_valid_pc("redir_target", 32'h100, 10);
    tick();
    chk("redir_next_pc", IF_PC_o, 32'h104);
    lat = 1;
    for (int i = 0; i < 3; i++) tick();

    // Grant withheld for four cycles
    Imem_gnt_i = 1'b0;
    held = exp_addr;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("nognt_req", {31'h0, Imem_req_o}, 32'h1);
      chk("nognt_addr", Imem_addr_o, held);
      tick();
    end
    chk("nognt_bubble", {31'h0, IF_valid_o}, 32'h0);
    Imem_gnt_i = 1'b1;
    #1;
    chk("gnt_resume_addr", Imem_addr_o, held);
    wait_valid_pc("gnt_resume", held, 8);

    // Redirect and stall in the same cycle: redirect wins
    ID_stall_i = 1'b1;
    PCSrc_i = 1'b1;
    Branch_target_i = 32'h0000_0200;
    tick();
    ID_stall_i = 1'b0;
    PCSrc_i = 1'b0;
    Branch_target_i = 32'h0;
    #1;
    chk("both_bubble_valid", {31'h0, IF_valid_o}, 32'h0);
    chk("both_bubble_instr", IF_Instruction_o, NOP);
    chk("both_addr", Imem_addr_o, 32'h200);
    wait_valid_pc("both_target", 32'h200, 10);

    // Asynchronous reset mid-stream with the response buffer full
    ID_stall_i = 1'b1;
    tick();
    tick();
    tick();
    chk("full_no_req", {31'h0, Imem_req_o}, 32'h0);
    #2;
    rst_i = 1'b1;
    Imem_rvalid_i = 1'b0;
    #1;
    chk("async_rst_instr", IF_Instruction_o, NOP);
    chk("async_rst_pc", IF_PC_o, 32'h0);
    chk("async_rst_valid", {31'h0, IF_valid_o}, 32'h0);
    chk("async_rst_req", {31'h0, Imem_req_o}, 32'h0);
    chk("async_rst_addr", Imem_addr_o, 32'h0);
    ID_stall_i = 1'b0;
    tick();
    tick();
    rst_i = 1'b0;
    #1;
    chk("post_rst_req", {31'h0, Imem_req_o}, 32'h1);
    chk("post_rst_addr", Imem_addr_o, 32'h0);
    wait_valid_pc("post_rst", 32'h0, 6);
    for (int i = 0; i < 3; i++) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
